// File: rtl/aes_pkg.sv
// Shared AES constants and types: the forward S-box table and the key-schedule round constants.
// Both the key schedule and the round datapath's SubBytes use this package.
package aes_pkg;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_block_t;

   // Indexed by j/2 of the key being generated; only entries 1..7 are ever used.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte; four of these form SubWord in the key schedule.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data,
   output logic [7:0] result
);

   assign result = SBOX[data];

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: takes one 256-bit cipher key and streams round keys 0..NR over valid/ready.
// A holds the key being presented, B the next one; N is built from both one key ahead of emission.
module aes256_key_expand
   import aes_pkg::*;
#(
   parameter int NR = 14
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [255:0] key,
   output logic         key_ready,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_idx,
   output logic         rk_last
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [3:0] LAST_IDX = 4'(NR);

   state_t     state;
   aes_block_t a;
   aes_block_t b;
   aes_block_t n;
   aes_word_t  b3;
   aes_word_t  sub_in;
   aes_word_t  sub_out;
   aes_word_t  t;
   aes_word_t  n0, n1, n2, n3;
   logic [4:0] j;
   logic [7:0] rcon;

   // Next-key function: j is the index of the round key being generated into B.
   always_comb begin
      j      = {1'b0, rk_idx} + 5'd2;
      b3     = b[31:0];
      sub_in = j[0] ? b3 : {b3[23:0], b3[31:24]};
      rcon   = j[0] ? 8'h00 : RCON[j[4:1]];
      t      = sub_out ^ {rcon, 24'h000000};
      n0     = a[127:96] ^ t;
      n1     = a[95:64]  ^ n0;
      n2     = a[63:32]  ^ n1;
      n3     = a[31:0]   ^ n2;
      n      = {n0, n1, n2, n3};
   end

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .data   (sub_in[8*i +: 8]),
         .result (sub_out[8*i +: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         key_ready <= 1'b1;
         rk_valid  <= 1'b0;
         rk_idx    <= 4'd0;
         a         <= '0;
         b         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (key_valid) begin
                  a         <= key[255:128];
                  b         <= key[127:0];
                  rk_idx    <= 4'd0;
                  rk_valid  <= 1'b1;
                  key_ready <= 1'b0;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               // rk_valid is always high here, so rk_ready alone marks a handshake.
               if (rk_ready) begin
                  if (rk_idx == LAST_IDX) begin
                     rk_valid  <= 1'b0;
                     key_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     a      <= b;
                     b      <= n;
                     rk_idx <= rk_idx + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rk      = a;
   assign rk_last = rk_valid && (rk_idx == LAST_IDX);

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand using the FIPS-197 A.3 key and the all-zero key.
module tb_aes256_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic [255:0] key;
   logic         key_ready;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk;
   logic [3:0]   rk_idx;
   logic         rk_last;

   int vectors = 0;
   int errors  = 0;

   logic [127:0] exp_rk [15];

   localparam logic [255:0] KEY_A3 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY_ZERO = 256'h0;

   aes256_key_expand dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key       (key),
      .key_ready (key_ready),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk        (rk),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      vectors++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   task automatic load_a3();
      exp_rk[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
      exp_rk[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
      exp_rk[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
      exp_rk[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
      exp_rk[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
      exp_rk[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
      exp_rk[6]  = 128'h812c81addadf48ba24360af2fab8b464;
      exp_rk[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
      exp_rk[8]  = 128'h68007bacb2df331696e939e46c518d80;
      exp_rk[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
      exp_rk[10] = 128'hde1369676ccc5a71fa2563959674ee15;
      exp_rk[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
      exp_rk[12] = 128'h749c47ab18501ddae2757e4f7401905a;
      exp_rk[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
      exp_rk[14] = 128'hfe4890d1e6188d0b046df344706c631e;
   endtask

   // Only the first four zero-key round keys are checked by value.
   task automatic load_zero();
      for (int i = 0; i < 15; i++) exp_rk[i] = '0;
      exp_rk[2] = {4{32'h62636363}};
      exp_rk[3] = {4{32'haafbfbfb}};
   endtask

   // Offer a key in IDLE and confirm the first round key shows up one cycle later.
   task automatic send_key(input logic [255:0] k);
      chk("key_ready_idle", key_ready, 1'b1);
      key_valid = 1'b1;
      key       = k;
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("first_latency", rk_valid, 1'b1);
   endtask

   // Consume nhs round keys; checks values of the first nchk, holds stable under stall.
   task automatic drain(input int nchk, input int stall_idx, input bit rnd, input int nhs);
      int got = 0;
      int cyc = 0;
      int stall_cnt = 0;
      bit stalled = 1'b0;
      logic [127:0] held_rk  = '0;
      logic [3:0]   held_idx = '0;
      while (got < nhs && cyc < 300) begin
         if (rk_valid) begin
            if (stalled) begin
               chk("stall_rk", rk, held_rk);
               chk("stall_idx", rk_idx, held_idx);
            end else begin
               if (got < nchk) chk($sformatf("rk%0d", got), rk, exp_rk[got]);
               chk("rk_idx", rk_idx, got[3:0]);
               chk("rk_last", rk_last, got == 14);
            end
            chk("key_ready_stream", key_ready, 1'b0);
            if (rnd)
               rk_ready = ($urandom_range(0, 2) != 0);
            else if (got == stall_idx && stall_cnt < 3) begin
               rk_ready = 1'b0;
               stall_cnt++;
            end else
               rk_ready = 1'b1;
            if (rk_ready) begin
               got++;
               stalled = 1'b0;
            end else begin
               stalled  = 1'b1;
               held_rk  = rk;
               held_idx = rk_idx;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      rk_ready = 1'b1;
      chk("handshake_count", got, nhs);
      if (nhs == 15) begin
         chk("end_rk_valid", rk_valid, 1'b0);
         chk("end_key_ready", key_ready, 1'b1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key       = '0;
      rk_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_key_ready", key_ready, 1'b1);
      chk("rst_rk_valid", rk_valid, 1'b0);
      chk("rst_rk", rk, 128'h0);
      chk("rst_rk_idx", rk_idx, 4'd0);
      chk("rst_rk_last", rk_last, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      // A.3 key, no back-pressure
      load_a3();
      send_key(KEY_A3);
      drain(15, -1, 1'b0, 15);

      // all-zero key
      load_zero();
      send_key(KEY_ZERO);
      drain(4, -1, 1'b0, 15);

      // A.3 with a three-cycle stall after idx 5, then random back-pressure
      load_a3();
      send_key(KEY_A3);
      drain(15, 6, 1'b0, 15);
      send_key(KEY_A3);
      drain(15, -1, 1'b1, 15);

      // Second key offered during the stream: ignored, then queued back-to-back
      send_key(KEY_A3);
      key_valid = 1'b1;
      key       = KEY_ZERO;
      drain(15, -1, 1'b0, 15);
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("b2b_rk_valid", rk_valid, 1'b1);
      load_zero();
      drain(4, -1, 1'b0, 15);

      // Reset after idx 7 handshake, with key_valid asserted alongside
      load_a3();
      send_key(KEY_A3);
      drain(15, -1, 1'b0, 8);
      rst       = 1'b1;
      key_valid = 1'b1;
      key       = KEY_A3;
      @(posedge clk); #1;
      rst       = 1'b0;
      key_valid = 1'b0;
      chk("mid_rst_rk_valid", rk_valid, 1'b0);
      chk("mid_rst_key_ready", key_ready, 1'b1);
      chk("mid_rst_rk_idx", rk_idx, 4'd0);
      chk("mid_rst_rk", rk, 128'h0);
      @(posedge clk); #1;
      chk("mid_rst_no_accept", rk_valid, 1'b0);
      send_key(KEY_A3);
      drain(15, -1, 1'b0, 15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
